ec_pt_mult_sched: RTL and testbench

EC_PT_MULT_SCHED -- requirements
Module: ec_pt_mult_sched

---
 rtl/ec_pt_mult_sched_if.sv | 18 +
 rtl/ec_pt_mult_sched.sv | 145 ++++++++++++++
 tb/tb_ec_pt_mult_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ec_pt_mult_sched_if.sv
// Valid/ready stream bundle: one beat carries a data word, a control word and an error flag.
interface if_axi_stream #(
    parameter int DAT_BITS = 32,
    parameter int CTL_BITS = 8,
    parameter int MOD_BITS = 1
);
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic                err;
    logic [MOD_BITS-1:0] mod;
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;

    modport source (output val, sop, eop, err, mod, dat, ctl, input rdy);
    modport sink   (input val, sop, eop, err, mod, dat, ctl, output rdy);
endinterface

// File: rtl/ec_pt_mult_sched.sv
// In-order scheduler: queues point-multiply requests, keeps one job in the external
// multiplier at a time, and bypasses zero scalars straight to the point at infinity.
module ec_pt_mult_sched #(
    parameter int  P        = 251,
    parameter type FP_TYPE  = logic [31:0],
    parameter int  DAT_BITS = $clog2(P),
    parameter int  TAG_BITS = 8,
    parameter int  DEPTH    = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    if_axi_stream.sink               i_req,
    if_axi_stream.source             o_pt_mult,
    if_axi_stream.sink               i_pt_mult,
    if_axi_stream.source             o_res,
    output logic [$clog2(DEPTH):0]   o_occ,
    output logic [15:0]              o_jobs
);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int OCC_BITS = PTR_BITS + 1;
    localparam logic [OCC_BITS-1:0] OCC_FULL = OCC_BITS'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [PTR_BITS-1:0]   rd_ptr;
    logic [OCC_BITS-1:0]   occ;
    FP_TYPE                mem_pt  [DEPTH];
    logic [DAT_BITS-1:0]   mem_sc  [DEPTH];
    logic [TAG_BITS-1:0]   mem_tag [DEPTH];
    logic [DAT_BITS-1:0]   head_sc;
    FP_TYPE                job_pt;
    logic [DAT_BITS-1:0]   job_sc;
    logic [TAG_BITS-1:0]   job_tag;
    FP_TYPE                res_pt;
    logic                  res_err;
    logic [15:0]           jobs;
    logic                  push;
    logic                  pop;
    logic                  res_hs;
    logic                  out_hs;

    always_comb begin
        head_sc = mem_sc[rd_ptr];
        push    = i_req.val && (occ < OCC_FULL);
        pop     = (state == IDLE) && (occ != '0);
        res_hs  = (state == WAIT) && i_pt_mult.val;
        out_hs  = (state == OUTPUT) && o_res.rdy;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop) state_nxt = (head_sc != '0) ? ISSUE : OUTPUT;
            ISSUE:   if (o_pt_mult.rdy) state_nxt = WAIT;
            WAIT:    if (i_pt_mult.val) state_nxt = OUTPUT;
            OUTPUT:  if (o_res.rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        i_req.rdy     = (occ < OCC_FULL);
        o_pt_mult.val = (state == ISSUE);
        o_pt_mult.dat = job_pt;
        o_pt_mult.ctl = job_sc;
        o_pt_mult.err = 1'b0;
        o_pt_mult.sop = 1'b1;
        o_pt_mult.eop = 1'b1;
        o_pt_mult.mod = '0;
        i_pt_mult.rdy = (state == WAIT);
        o_res.val     = (state == OUTPUT);
        o_res.dat     = res_pt;
        o_res.ctl     = job_tag;
        o_res.err     = res_err;
        o_res.sop     = 1'b1;
        o_res.eop     = 1'b1;
        o_res.mod     = '0;
    end

    // Occupancy is the only full/empty source; pointers simply wrap at DEPTH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OCC_BITS'(1);
                2'b01:   occ <= occ - OCC_BITS'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_pt[wr_ptr]  <= FP_TYPE'(i_req.dat);
            mem_sc[wr_ptr]  <= i_req.ctl[DAT_BITS-1:0];
            mem_tag[wr_ptr] <= i_req.ctl[DAT_BITS +: TAG_BITS];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            job_pt  <= '0;
            job_sc  <= '0;
            job_tag <= '0;
            res_pt  <= '0;
            res_err <= 1'b0;
            jobs    <= '0;
        end else begin
            if (pop) begin
                job_pt  <= mem_pt[rd_ptr];
                job_sc  <= head_sc;
                job_tag <= mem_tag[rd_ptr];
                if (head_sc == '0) begin
                    res_pt  <= '0;
                    res_err <= 1'b0;
                end
            end
            if (res_hs) begin
                res_pt  <= i_pt_mult.err ? '0 : FP_TYPE'(i_pt_mult.dat);
                res_err <= i_pt_mult.err;
            end
            if (out_hs) jobs <= jobs + 16'd1;
        end
    end

    assign o_occ  = occ;
    assign o_jobs = jobs;

    logic unused_sig;
    assign unused_sig = ^{i_req.sop, i_req.eop, i_req.mod, i_req.err,
                          i_pt_mult.ctl, i_pt_mult.sop, i_pt_mult.eop, i_pt_mult.mod};
endmodule

// File: tb/tb_ec_pt_mult_sched.sv
// Bench for ec_pt_mult_sched: transaction-level model, multiplier responder, directed scenarios.
module tb_ec_pt_mult_sched;
    localparam int DEPTH = 4;
    localparam int LAT   = 3;
    localparam logic [7:0] ERR_K = 8'hEE;

    typedef struct {
        logic [31:0] pt;
        logic [7:0]  k;
        logic [7:0]  tag;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  o_occ;
    logic [15:0] o_jobs;
    logic        mul_accept_en;
    logic        spur_en;
    int          checks = 0;
    int          failures = 0;

    req_t        fifo_m[$];
    req_t        cur;
    logic        m_busy, m_pend, m_out;
    int          m_jobs;
    logic [7:0]  tags_seen[$];

    if_axi_stream #(.DAT_BITS(32), .CTL_BITS(16)) req_if ();
    if_axi_stream #(.DAT_BITS(32), .CTL_BITS(8))  job_if ();
    if_axi_stream #(.DAT_BITS(32), .CTL_BITS(8))  mres_if ();
    if_axi_stream #(.DAT_BITS(32), .CTL_BITS(8))  res_if ();

    ec_pt_mult_sched #(
        .P(251), .FP_TYPE(logic [31:0]), .TAG_BITS(8), .DEPTH(DEPTH)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req(req_if), .o_pt_mult(job_if), .i_pt_mult(mres_if), .o_res(res_if),
        .o_occ(o_occ), .o_jobs(o_jobs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_dat(input req_t r);
        if (r.k == 8'd0 || r.k == ERR_K) return 32'd0;
        return r.pt * {24'd0, r.k};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [31:0] pt, input logic [7:0] k, input logic [7:0] tag);
        int n = 0;
        req_if.val = 1'b1;
        req_if.dat = pt;
        req_if.ctl = {tag, k};
        forever begin
            @(negedge clk);
            if (req_if.rdy) break;
            n++;
            if (n > 200) begin
                chk("push_timeout", 0, 1);
                break;
            end
        end
        tick();
        req_if.val = 1'b0;
    endtask

    task automatic wait_res();
        int n = 0;
        forever begin
            @(negedge clk);
            if (res_if.val) break;
            n++;
            if (n > 200) begin
                chk("res_timeout", 0, 1);
                break;
            end
        end
    endtask

    // Multiplier responder: takes one job, answers LAT cycles later; ERR_K yields an error.
    initial begin : mult_model
        logic take, give, busy;
        int cnt;
        logic [31:0] m_pt;
        logic [7:0] m_k;
        busy = 1'b0; cnt = 0; m_pt = '0; m_k = '0;
        mres_if.val = 1'b0; mres_if.dat = '0; mres_if.err = 1'b0; mres_if.ctl = '0;
        mres_if.sop = 1'b1; mres_if.eop = 1'b1; mres_if.mod = '0;
        job_if.rdy = 1'b0;
        forever begin
            @(negedge clk);
            take = job_if.val && job_if.rdy;
            give = mres_if.val && mres_if.rdy;
            if (take) begin
                m_pt = job_if.dat;
                m_k  = job_if.ctl;
            end
            tick();
            if (!rst_n) begin
                busy = 1'b0;
                mres_if.val = 1'b0;
            end else begin
                if (give) begin
                    busy = 1'b0;
                    mres_if.val = 1'b0;
                end
                if (take) begin
                    busy = 1'b1;
                    cnt = LAT;
                    mres_if.val = 1'b0;
                end else if (busy && !mres_if.val) begin
                    if (cnt <= 1) begin
                        mres_if.val = 1'b1;
                        mres_if.err = (m_k == ERR_K);
                        mres_if.dat = (m_k == ERR_K) ? 32'hDEAD_BEEF : m_pt * {24'd0, m_k};
                    end else cnt--;
                end else if (!busy) begin
                    mres_if.val = spur_en;
                    mres_if.dat = 32'hBAD0_BAD0;
                    mres_if.err = 1'b1;
                end
            end
            job_if.rdy = mul_accept_en && !busy;
        end
    end

    // Transaction model: FIFO of requests, one job in service, handshakes derived from inputs.
    initial begin : compare
        logic push_m, pop_m, iss_m, res_m, out_m, wait_m;
        req_t r;
        m_busy = 0; m_pend = 0; m_out = 0; m_jobs = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                fifo_m.delete();
                m_busy = 0; m_pend = 0; m_out = 0; m_jobs = 0;
                chk("rst_occ", o_occ, 0);
                chk("rst_jobs", o_jobs, 0);
                chk("rst_iss_val", job_if.val, 0);
                chk("rst_res_val", res_if.val, 0);
                chk("rst_mul_rdy", mres_if.rdy, 0);
                chk("rst_res_err", res_if.err, 0);
            end else begin
                wait_m = m_busy && !m_pend && !m_out;
                chk("req_rdy", req_if.rdy, fifo_m.size() < DEPTH);
                chk("occ", o_occ, fifo_m.size());
                chk("jobs", o_jobs, m_jobs[15:0]);
                chk("iss_val", job_if.val, m_pend);
                chk("mul_rdy", mres_if.rdy, wait_m);
                chk("res_val", res_if.val, m_out);
                if (m_pend) begin
                    chk("iss_dat", job_if.dat, cur.pt);
                    chk("iss_ctl", job_if.ctl, cur.k);
                    chk("iss_flags", {job_if.sop, job_if.eop, job_if.mod}, 3'b110);
                end
                if (m_out) begin
                    chk("res_dat", res_if.dat, exp_dat(cur));
                    chk("res_tag", res_if.ctl, cur.tag);
                    chk("res_err", res_if.err, cur.k == ERR_K);
                    chk("res_flags", {res_if.sop, res_if.eop, res_if.mod}, 3'b110);
                end
                push_m = req_if.val && (fifo_m.size() < DEPTH);
                pop_m  = !m_busy && (fifo_m.size() != 0);
                iss_m  = m_pend && job_if.rdy;
                res_m  = wait_m && mres_if.val;
                out_m  = m_out && res_if.rdy;
                if (out_m) begin
                    m_out = 0; m_busy = 0; m_jobs++;
                    tags_seen.push_back(cur.tag);
                end
                if (pop_m) begin
                    cur = fifo_m.pop_front();
                    m_busy = 1;
                    if (cur.k == 8'd0) m_out = 1;
                    else               m_pend = 1;
                end
                if (iss_m) m_pend = 0;
                if (res_m) m_out = 1;
                if (push_m) begin
                    r.pt = req_if.dat; r.k = req_if.ctl[7:0]; r.tag = req_if.ctl[15:8];
                    fifo_m.push_back(r);
                end
            end
        end
    end

    initial begin : main
        int base;
        rst_n = 1'b0;
        req_if.val = 1'b0; req_if.dat = '0; req_if.ctl = '0; req_if.err = 1'b0;
        req_if.sop = 1'b1; req_if.eop = 1'b1; req_if.mod = '0;
        res_if.rdy = 1'b1;
        mul_accept_en = 1'b1;
        spur_en = 1'b0;
        repeat (3) @(posedge clk);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", req_if.rdy, 1);
        tick();

        // Result beats offered outside WAIT must be ignored.
        spur_en = 1'b1;
        repeat (5) tick();
        spur_en = 1'b0;
        repeat (2) tick();
        chk("spur_jobs", o_jobs, 0);
        chk("spur_occ", o_occ, 0);

        // G * 5
        push(32'h0000_1234, 8'd5, 8'h11);
        @(negedge clk);
        chk("g5_iss_t1", job_if.val, 0);
        @(negedge clk);
        chk("g5_iss_t2", job_if.val, 1);
        chk("g5_iss_ctl", job_if.ctl, 8'd5);
        wait_res();
        chk("g5_dat", res_if.dat, 32'h0000_5B04);
        chk("g5_tag", res_if.ctl, 8'h11);
        chk("g5_err", res_if.err, 0);
        @(negedge clk);
        chk("g5_jobs", o_jobs, 1);
        tick();

        // Zero scalar bypass
        push(32'h0000_0777, 8'd0, 8'h22);
        @(negedge clk);
        chk("z_res_t1", res_if.val, 0);
        @(negedge clk);
        chk("z_res_t2", res_if.val, 1);
        chk("z_dat", res_if.dat, 0);
        chk("z_tag", res_if.ctl, 8'h22);
        chk("z_iss", job_if.val, 0);
        tick();
        tick();

        // Fill the FIFO behind a stalled multiplier
        mul_accept_en = 1'b0;
        tick();
        base = tags_seen.size();
        for (int i = 1; i <= 5; i++) push(32'h100 * i, 8'(i + 1), 8'(i));
        req_if.val = 1'b1;
        req_if.ctl = {8'd6, 8'd9};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_occ", o_occ, 4);
            chk("full_rdy", req_if.rdy, 0);
        end
        tick();
        req_if.val = 1'b0;
        mul_accept_en = 1'b1;
        for (int n = 0; n < 400 && tags_seen.size() < base + 5; n++) @(negedge clk);
        chk("drain_count", tags_seen.size(), base + 5);
        for (int i = 0; i < 5; i++)
            if (base + i < tags_seen.size()) chk("drain_order", tags_seen[base + i], i + 1);
        @(negedge clk);
        chk("drain_occ", o_occ, 0);
        tick();

        // Multiplier error, then a normal job behind it
        push(32'h0000_0101, ERR_K, 8'h33);
        push(32'h0000_0202, 8'd3, 8'h34);
        wait_res();
        chk("err_flag", res_if.err, 1);
        chk("err_dat", res_if.dat, 0);
        chk("err_tag", res_if.ctl, 8'h33);
        wait_res();
        chk("post_err_tag", res_if.ctl, 8'h34);
        chk("post_err_dat", res_if.dat, 32'h0000_0606);
        chk("post_err_flag", res_if.err, 0);
        tick();

        // Output back-pressure with a push arriving
        res_if.rdy = 1'b0;
        push(32'h0000_0055, 8'd0, 8'h44);
        wait_res();
        tick();
        push(32'h0000_0066, 8'd2, 8'h45);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_val", res_if.val, 1);
            chk("bp_tag", res_if.ctl, 8'h44);
            chk("bp_occ", o_occ, 1);
        end
        tick();
        res_if.rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_nopop", o_occ, 1);
        chk("bp_released", res_if.val, 0);
        @(negedge clk);
        chk("bp_pop", o_occ, 0);
        wait_res();
        chk("bp_next_tag", res_if.ctl, 8'h45);
        tick();
        tick();

        // Reset while a job sits in the multiplier with two queued
        push(32'h0000_0070, 8'd7, 8'h51);
        push(32'h0000_0071, 8'd7, 8'h52);
        push(32'h0000_0072, 8'd7, 8'h53);
        for (int n = 0; n < 50 && !mres_if.rdy; n++) @(negedge clk);
        chk("wait_seen", mres_if.rdy, 1);
        chk("wait_occ", o_occ, 2);
        tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rr_rdy", req_if.rdy, 1);
        chk("rr_occ", o_occ, 0);
        chk("rr_vals", {job_if.val, res_if.val, mres_if.val}, 0);
        tick();
        push(32'h0000_0080, 8'd2, 8'h60);
        wait_res();
        chk("rr_tag", res_if.ctl, 8'h60);
        chk("rr_dat", res_if.dat, 32'h0000_0100);
        @(negedge clk);
        chk("rr_jobs", o_jobs, 1);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
